stream_merge: RTL

STREAM_MERGE -- requirements
Module: stream_merge

---
 rtl/stream_merge_pkg.sv | 7 +
 rtl/stream_merge_if.sv | 9 +
 rtl/stream_merge_rr_arb.sv | 26 ++
 rtl/stream_merge.sv | 71 +++++++
 4 files changed

// File: rtl/stream_merge_pkg.sv
// stream_merge_pkg: shared constants for the stream_merge block.
// Contents: source-tag constants SRC_S1/SRC_S2 and the last-grant state encoding last_t.
package stream_merge_pkg;
    localparam logic SRC_S1 = 1'b0;
    localparam logic SRC_S2 = 1'b1;
    typedef enum logic {LAST1 = 1'b0, LAST2 = 1'b1} last_t;
endpackage

// File: rtl/stream_merge_if.sv
// stream_merge_if: valid/rdy/data stream bundle used by stream_merge.
// Ports: valid (master->slave), data [W-1:0] (master->slave), rdy (slave->master).
interface stream_merge_if #(parameter int W = 128);
    logic         valid;
    logic         rdy;
    logic [W-1:0] data;
    modport master (output valid, output data, input rdy);
    modport slave (input valid, input data, output rdy);
endinterface

// File: rtl/stream_merge_rr_arb.sv
// stream_merge_rr_arb: 2-way round-robin grant with a 1-bit last-grant register.
// Ports: clk, rst (sync, active-high), take (output slot can accept),
//        req1/req2 (source valids), gnt1/gnt2 (one-hot grants, used directly as source rdy).
module stream_merge_rr_arb
    import stream_merge_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic take,
    input  logic req1,
    input  logic req2,
    output logic gnt1,
    output logic gnt2
);
    last_t last;
    // Grants look only at valids and the last-grant state, never at data.
    always_comb begin
        gnt1 = ~rst & take & req1 & (~req2 | (last == LAST2));
        gnt2 = ~rst & take & req2 & (~req1 | (last == LAST1));
    end
    always_ff @(posedge clk) begin
        if (rst) last <= LAST2;
        else if (gnt1) last <= LAST1;
        else if (gnt2) last <= LAST2;
    end
endmodule

// File: rtl/stream_merge.sv
// stream_merge: merges two valid/rdy streams into one through a single registered slot.
// Ports: clk, rst (sync, active-high), s1i/s2i (slave streams), so (master stream),
//        so_src (tag of so.data: 0 = source 1, 1 = source 2), cnt1/cnt2 (delivered-beat counts).
// Macro STREAM_MERGE_CNT_EN: enables saturating delivered-beat counters; otherwise cnt1/cnt2 are 0.
module stream_merge
    import stream_merge_pkg::*;
#(
    parameter int W  = 128,
    parameter int CW = 32
)
(
    input  logic              clk,
    input  logic              rst,
    stream_merge_if.slave     s1i,
    stream_merge_if.slave     s2i,
    stream_merge_if.master    so,
    output logic              so_src,
    output logic [CW-1:0]     cnt1,
    output logic [CW-1:0]     cnt2
);
    logic         take, gnt1, gnt2, valid_q, src_q;
    logic [W-1:0] data_q;
    // The slot can be refilled when empty or being drained this cycle.
    assign take = ~valid_q | so.rdy;
    stream_merge_rr_arb u_arb (
        .clk  (clk),
        .rst  (rst),
        .take (take),
        .req1 (s1i.valid),
        .req2 (s2i.valid),
        .gnt1 (gnt1),
        .gnt2 (gnt2)
    );
    assign s1i.rdy = gnt1;
    assign s2i.rdy = gnt2;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= SRC_S1;
        end else if (take) begin
            valid_q <= gnt1 | gnt2;
            if (gnt1 | gnt2) begin
                data_q <= gnt2 ? s2i.data : s1i.data;
                src_q  <= gnt2 ? SRC_S2 : SRC_S1;
            end
        end
    end
    assign so.valid = valid_q;
    assign so.data  = data_q;
    assign so_src   = src_q;
`ifdef STREAM_MERGE_CNT_EN
    logic [CW-1:0] c1, c2;
    logic          out_xfer;
    assign out_xfer = valid_q & so.rdy;
    always_ff @(posedge clk) begin
        if (rst) begin
            c1 <= '0;
            c2 <= '0;
        end else if (out_xfer) begin
            if (src_q == SRC_S1 && ~&c1) c1 <= c1 + 1'b1;
            if (src_q == SRC_S2 && ~&c2) c2 <= c2 + 1'b1;
        end
    end
    assign cnt1 = c1;
    assign cnt2 = c2;
`else
    assign cnt1 = '0;
    assign cnt2 = '0;
`endif
endmodule
